// File: rtl/packet_serializer_if.sv
// Frame-load and serial-output signal bundle between the packet sorter,
// the serializer and the BPSK modulator.
interface packet_serializer_if #(
  parameter int unsigned FRAME_WIDTH = 224
);
  logic [FRAME_WIDTH-1:0] frame_in;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   bit_out;
  logic                   bit_strobe;
  logic                   tx_active;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready,
    input  bit_out,
    input  bit_strobe,
    input  tx_active,
    input  frame_done,
    input  overrun
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready,
    output bit_out,
    output bit_strobe,
    output tx_active,
    output frame_done,
    output overrun
  );
endinterface

// File: rtl/packet_serializer.sv
// Captures one sorted frame and shifts it out LSB first, each bit held for
// SAMPLES_PER_BIT cycles, followed by a GAP_CYCLES idle guard interval.
module packet_serializer #(
  parameter int unsigned PACKET_WIDTH    = 16,
  parameter int unsigned INDEX_WIDTH     = 4,
  parameter int unsigned PREAMBLE_LENGTH = 32,
  parameter int unsigned SAMPLES_PER_BIT = 8,
  parameter int unsigned GAP_CYCLES      = 16,
  localparam int unsigned FRAME_WIDTH    = PACKET_WIDTH*(8+INDEX_WIDTH)+PREAMBLE_LENGTH
) (
  input  logic               clk,
  input  logic               rst_n,
  packet_serializer_if.slave bus
);

  localparam int unsigned BC_W = (FRAME_WIDTH > 1)     ? $clog2(FRAME_WIDTH)     : 1;
  localparam int unsigned SC_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned GC_W = (GAP_CYCLES > 1)      ? $clog2(GAP_CYCLES)      : 1;

  localparam logic [BC_W-1:0] BIT_LAST    = BC_W'(FRAME_WIDTH - 1);
  localparam logic [SC_W-1:0] SAMPLE_LAST = SC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [GC_W-1:0] GAP_LAST    = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e                 state_q,      state_d;
  logic [FRAME_WIDTH-1:0] shreg_q,      shreg_d;
  logic [BC_W-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [SC_W-1:0]        sample_cnt_q, sample_cnt_d;
  logic [GC_W-1:0]        gap_cnt_q,    gap_cnt_d;

  logic frame_ready_q, frame_ready_d;
  logic bit_out_q,     bit_out_d;
  logic bit_strobe_q,  bit_strobe_d;
  logic tx_active_q,   tx_active_d;
  logic frame_done_q,  frame_done_d;
  logic overrun_q,     overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      sample_cnt_q  <= '0;
      gap_cnt_q     <= '0;
      frame_ready_q <= 1'b1;
      bit_out_q     <= 1'b0;
      bit_strobe_q  <= 1'b0;
      tx_active_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_ready_q <= frame_ready_d;
      bit_out_q     <= bit_out_d;
      bit_strobe_q  <= bit_strobe_d;
      tx_active_q   <= tx_active_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  // Outputs are computed for the next state so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_ready_d = frame_ready_q;
    bit_out_d     = bit_out_q;
    bit_strobe_d  = 1'b0;
    tx_active_d   = tx_active_q;
    frame_done_d  = 1'b0;
    overrun_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        frame_ready_d = 1'b1;
        tx_active_d   = 1'b0;
        bit_out_d     = 1'b0;
        if (bus.frame_valid) begin
          state_d       = S_SHIFT;
          shreg_d       = bus.frame_in;
          bit_cnt_d     = '0;
          sample_cnt_d  = '0;
          frame_ready_d = 1'b0;
          tx_active_d   = 1'b1;
          bit_out_d     = bus.frame_in[0];
          bit_strobe_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        overrun_d = bus.frame_valid;
        if (sample_cnt_q == SAMPLE_LAST) begin
          sample_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            tx_active_d  = 1'b0;
            bit_out_d    = 1'b0;
            frame_done_d = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d       = S_IDLE;
              frame_ready_d = 1'b1;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            // The bit about to be presented is shreg_q[1], i.e. bit 0 after this shift.
            shreg_d      = shreg_q >> 1;
            bit_cnt_d    = bit_cnt_q + 1'b1;
            bit_out_d    = shreg_q[1];
            bit_strobe_d = 1'b1;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        overrun_d = bus.frame_valid;
        if (gap_cnt_q == GAP_LAST) begin
          state_d       = S_IDLE;
          frame_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d       = S_IDLE;
        frame_ready_d = 1'b1;
        tx_active_d   = 1'b0;
        bit_out_d     = 1'b0;
      end
    endcase
  end

  assign bus.frame_ready = frame_ready_q;
  assign bus.bit_out     = bit_out_q;
  assign bus.bit_strobe  = bit_strobe_q;
  assign bus.tx_active   = tx_active_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;

endmodule
